// File: rtl/counter_pkg.sv
// Shared definitions for the 4-bit up/down counter and its request generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  // Width of one incr/decr step and the largest step the counter takes per cycle.
  localparam int STEP_W   = 2;
  localparam int STEP_MAX = 3;

  // Counter value width.
  localparam int VALUE_W  = 4;

  // Re-initialisation sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2,
    ACK   = 2'd3
  } reinit_state_t;

endpackage

// File: rtl/counter_req_gen_if.sv
// Bundle between event producers / re-init requester and the counter_req_gen block.
// Latency: n/a (wiring only).
// Backpressure: evt_valid/evt_ready per direction; reinit_req is a level held until reinit_ack.
//
// Signals:
//   inc_evt_valid/cnt/ready, dec_evt_valid/cnt/ready : event offers, 0..3 units each
//   reinit_req, reinit_value, reinit_ack              : re-init request/acknowledge
//   incr_valid/incr, decr_valid/decr                  : steps to the counter
//   reinit, initial_value                             : counter reload
//   pend_inc, pend_dec, busy                          : status
// Modports: slave = the generator, master = producers/requester side.
interface counter_req_gen_if #(
  parameter int PEND_W  = 4,
  parameter int VALUE_W = 4
);

  logic                            inc_evt_valid;
  logic [counter_pkg::STEP_W-1:0]  inc_evt_cnt;
  logic                            inc_evt_ready;
  logic                            dec_evt_valid;
  logic [counter_pkg::STEP_W-1:0]  dec_evt_cnt;
  logic                            dec_evt_ready;

  logic                            reinit_req;
  logic [VALUE_W-1:0]              reinit_value;
  logic                            reinit_ack;

  logic                            incr_valid;
  logic [counter_pkg::STEP_W-1:0]  incr;
  logic                            decr_valid;
  logic [counter_pkg::STEP_W-1:0]  decr;
  logic                            reinit;
  logic [VALUE_W-1:0]              initial_value;

  logic [PEND_W-1:0]               pend_inc;
  logic [PEND_W-1:0]               pend_dec;
  logic                            busy;

  modport slave (
    input  inc_evt_valid, inc_evt_cnt, dec_evt_valid, dec_evt_cnt,
    input  reinit_req, reinit_value,
    output inc_evt_ready, dec_evt_ready, reinit_ack,
    output incr_valid, incr, decr_valid, decr, reinit, initial_value,
    output pend_inc, pend_dec, busy
  );

  modport master (
    output inc_evt_valid, inc_evt_cnt, dec_evt_valid, dec_evt_cnt,
    output reinit_req, reinit_value,
    input  inc_evt_ready, dec_evt_ready, reinit_ack,
    input  incr_valid, incr, decr_valid, decr, reinit, initial_value,
    input  pend_inc, pend_dec, busy
  );

endinterface

// File: rtl/counter_req_lane.sv
// One direction of the request generator: pending backlog, min-3 drain and event accept.
// Latency: accepted event visible on o_drain the next cycle.
// Backpressure: o_evt_rdy low when i_en is low or the backlog is within 3 of full.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_en                : acceptance permitted (reset released, sequencer idle, no request)
//   i_flush             : synchronous clear of the backlog, overrides drain and accept
//   i_evt_vld/i_evt_cnt : event offer, 0..3 units
//   o_evt_rdy           : event accepted when i_evt_vld && o_evt_rdy
//   o_drain             : units leaving the backlog this cycle (register-decoded)
//   o_pend              : backlog register
module counter_req_lane
  import counter_pkg::*;
#(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_evt_vld,
  input  logic [STEP_W-1:0] i_evt_cnt,
  output logic              o_evt_rdy,
  output logic [STEP_W-1:0] o_drain,
  output logic [PEND_W-1:0] o_pend
);

  localparam logic [PEND_W-1:0] LP_STEP_MAX   = PEND_W'(STEP_MAX);
  // Leaving 3 units of headroom means one more accept can never wrap the backlog.
  localparam logic [PEND_W-1:0] LP_ACCEPT_LIM = PEND_W'((1 << PEND_W) - 4);

  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic [PEND_W-1:0] w_add;
  logic [STEP_W-1:0] w_drain;
  logic              w_rdy;
  logic              w_accept;

  always_comb begin
    w_drain    = (r_pend > LP_STEP_MAX) ? STEP_W'(STEP_MAX) : r_pend[STEP_W-1:0];
    w_rdy      = i_en && (r_pend <= LP_ACCEPT_LIM);
    w_accept   = i_evt_vld && w_rdy;
    w_add      = w_accept ? PEND_W'(i_evt_cnt) : '0;
    w_pend_nxt = i_flush ? '0 : (r_pend - PEND_W'(w_drain) + w_add);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign o_evt_rdy = w_rdy;
  assign o_drain   = w_drain;
  assign o_pend    = r_pend;

endmodule

// File: rtl/counter_req_gen.sv
// Request generator for the up/down counter: backlogs inc/dec events and sequences re-init.
// Latency: event accepted in cycle k drives incr/decr in k+1; reinit_req at k gives reinit at k+2, ack at k+3.
// Backpressure: evt readies low outside IDLE, while reinit_req is high, or with a near-full backlog.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : counter_req_gen_if.slave -- events, re-init handshake, counter drive, status
module counter_req_gen #(
  parameter int PEND_W  = 4,
  parameter int VALUE_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  counter_req_gen_if.slave   bus
);

  import counter_pkg::*;

  reinit_state_t      r_state;
  reinit_state_t      w_state_nxt;
  logic [VALUE_W-1:0] r_init_val;

  logic               w_idle;
  logic               w_en;
  logic               w_flush;

  logic               w_inc_rdy;
  logic               w_dec_rdy;
  logic [STEP_W-1:0]  w_inc_drain;
  logic [STEP_W-1:0]  w_dec_drain;
  logic [PEND_W-1:0]  w_pend_inc;
  logic [PEND_W-1:0]  w_pend_dec;

  assign w_idle  = (r_state == IDLE);
  // rst_n is included so the readies read 0 throughout reset, not just after the first edge.
  assign w_en    = rst_n && w_idle && !bus.reinit_req;
  assign w_flush = (r_state == FLUSH);

  counter_req_lane #(.PEND_W(PEND_W)) u_inc_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_flush   (w_flush),
    .i_evt_vld (bus.inc_evt_valid),
    .i_evt_cnt (bus.inc_evt_cnt),
    .o_evt_rdy (w_inc_rdy),
    .o_drain   (w_inc_drain),
    .o_pend    (w_pend_inc)
  );

  counter_req_lane #(.PEND_W(PEND_W)) u_dec_lane (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (w_en),
    .i_flush   (w_flush),
    .i_evt_vld (bus.dec_evt_valid),
    .i_evt_cnt (bus.dec_evt_cnt),
    .o_evt_rdy (w_dec_rdy),
    .o_drain   (w_dec_drain),
    .o_pend    (w_pend_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.reinit_req) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = LOAD;
      LOAD:    w_state_nxt = ACK;
      // reinit_req is deliberately not looked at here; the requester drops it after the ack.
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the load value when the request is taken so initial_value stays register-driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_val <= '0;
    end else if (w_idle && bus.reinit_req) begin
      r_init_val <= bus.reinit_value;
    end
  end

  assign bus.inc_evt_ready = w_inc_rdy;
  assign bus.dec_evt_ready = w_dec_rdy;

  // Steps only leave the backlog while idle; FLUSH discards whatever is still pending.
  assign bus.incr_valid    = w_idle && (w_inc_drain != '0);
  assign bus.incr          = w_idle ? w_inc_drain : '0;
  assign bus.decr_valid    = w_idle && (w_dec_drain != '0);
  assign bus.decr          = w_idle ? w_dec_drain : '0;

  assign bus.reinit        = (r_state == LOAD);
  assign bus.initial_value = (r_state == LOAD) ? r_init_val : '0;
  assign bus.reinit_ack    = (r_state == ACK);

  assign bus.pend_inc      = w_pend_inc;
  assign bus.pend_dec      = w_pend_dec;
  assign bus.busy          = (w_pend_inc != '0) || (w_pend_dec != '0) || !w_idle;

endmodule

// File: tb/tb_counter_req_gen.sv
module tb_counter_req_gen;

  localparam int PEND_W  = 4;
  localparam int VALUE_W = 4;
  localparam int LIMIT   = (1 << PEND_W) - 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  counter_req_gen_if #(.PEND_W(PEND_W), .VALUE_W(VALUE_W)) bus ();

  counter_req_gen #(.PEND_W(PEND_W), .VALUE_W(VALUE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: backlog totals and the number of cycles since a re-init was taken.
  int m_pinc, m_pdec, m_ph, m_val;

  // Expectations for the current cycle.
  bit                 e_irdy, e_drdy, e_iv, e_dv, e_reinit, e_ack, e_busy;
  logic [1:0]         e_inc, e_dec;
  logic [VALUE_W-1:0] e_init;
  logic [PEND_W-1:0]  e_pinc, e_pdec;

  function automatic int min3(input int p);
    return (p > 3) ? 3 : p;
  endfunction

  task automatic model_reset();
    m_pinc = 0; m_pdec = 0; m_ph = 0; m_val = 0;
  endtask

  task automatic model_expect();
    e_irdy   = (rst_n === 1'b1) && (m_ph == 0) && !bus.reinit_req && (m_pinc <= LIMIT);
    e_drdy   = (rst_n === 1'b1) && (m_ph == 0) && !bus.reinit_req && (m_pdec <= LIMIT);
    e_iv     = (m_ph == 0) && (m_pinc > 0);
    e_dv     = (m_ph == 0) && (m_pdec > 0);
    e_inc    = 2'(min3(m_pinc));
    e_dec    = 2'(min3(m_pdec));
    e_reinit = (m_ph == 2);
    e_init   = (m_ph == 2) ? VALUE_W'(m_val) : '0;
    e_ack    = (m_ph == 3);
    e_busy   = (m_pinc != 0) || (m_pdec != 0) || (m_ph != 0);
    e_pinc   = PEND_W'(m_pinc);
    e_pdec   = PEND_W'(m_pdec);
  endtask

  task automatic model_advance();
    int acc_i, acc_d;
    acc_i = (bus.inc_evt_valid && e_irdy) ? int'(bus.inc_evt_cnt) : 0;
    acc_d = (bus.dec_evt_valid && e_drdy) ? int'(bus.dec_evt_cnt) : 0;
    if (m_ph == 1) begin
      m_pinc = 0;
      m_pdec = 0;
    end else begin
      m_pinc = m_pinc - min3(m_pinc) + acc_i;
      m_pdec = m_pdec - min3(m_pdec) + acc_d;
    end
    if (m_ph == 0) begin
      if (bus.reinit_req) begin
        m_ph  = 1;
        m_val = int'(bus.reinit_value);
      end
    end else begin
      m_ph = (m_ph + 1) % 4;
    end
  endtask

  task automatic drive(input bit iv, input int ic, input bit dv, input int dc,
                       input bit rq, input int rv);
    bus.inc_evt_valid = iv;
    bus.inc_evt_cnt   = 2'(ic);
    bus.dec_evt_valid = dv;
    bus.dec_evt_cnt   = 2'(dc);
    bus.reinit_req    = rq;
    bus.reinit_value  = VALUE_W'(rv);
  endtask

  task automatic settle();
    #1;
    model_expect();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1, 3, 1, 2, 0, 0);
    #2;
    checks++; if (bus.inc_evt_ready !== 1'b0) begin errors++; $display("FAIL reset_inc_rdy: got %b want 0", bus.inc_evt_ready); end
    checks++; if (bus.dec_evt_ready !== 1'b0) begin errors++; $display("FAIL reset_dec_rdy: got %b want 0", bus.dec_evt_ready); end
    @(posedge clk); #1;
    checks++; if (bus.pend_inc !== 4'd0) begin errors++; $display("FAIL reset_pend_inc: got %0d want 0", bus.pend_inc); end
    checks++; if (bus.incr_valid !== 1'b0 || bus.decr_valid !== 1'b0) begin errors++; $display("FAIL reset_valids: got %b%b want 00", bus.incr_valid, bus.decr_valid); end
    checks++; if (bus.reinit !== 1'b0 || bus.reinit_ack !== 1'b0 || bus.initial_value !== 4'd0) begin errors++; $display("FAIL reset_reinit_outs: got %b %b %h want 0 0 0", bus.reinit, bus.reinit_ack, bus.initial_value); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    settle();
    tick();
    settle();
    checks++; if (bus.inc_evt_ready !== 1'b1) begin errors++; $display("FAIL release_inc_rdy: got %b want 1", bus.inc_evt_ready); end
    checks++; if (bus.dec_evt_ready !== 1'b1) begin errors++; $display("FAIL release_dec_rdy: got %b want 1", bus.dec_evt_ready); end
    tick();
  endtask

  task automatic test_single();
    drive(1, 3, 0, 0, 0, 0); settle();
    checks++; if (bus.inc_evt_ready !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", bus.inc_evt_ready); end
    tick();
    drive(0, 0, 0, 0, 0, 0); settle();
    checks++; if (bus.incr_valid !== 1'b1 || bus.incr !== 2'd3) begin errors++; $display("FAIL single_incr: got v=%b n=%0d want v=1 n=3", bus.incr_valid, bus.incr); end
    checks++; if (bus.decr_valid !== 1'b0) begin errors++; $display("FAIL single_decr_idle: got %b want 0", bus.decr_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    tick();
    settle();
    checks++; if (bus.pend_inc !== 4'd0 || bus.incr_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got pend=%0d v=%b want 0 0", bus.pend_inc, bus.incr_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_burst();
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 1, 2, 0, 0); settle();
      checks++; if (bus.inc_evt_ready !== e_irdy) begin errors++; $display("FAIL burst_rdy[%0d]: got %b want %b", i, bus.inc_evt_ready, e_irdy); end
      checks++; if (bus.pend_inc !== e_pinc || bus.pend_dec !== e_pdec) begin errors++; $display("FAIL burst_pend[%0d]: got %0d/%0d want %0d/%0d", i, bus.pend_inc, bus.pend_dec, e_pinc, e_pdec); end
      if (i > 0) begin
        checks++; if (bus.incr_valid !== 1'b1 || bus.incr !== 2'd3) begin errors++; $display("FAIL burst_incr[%0d]: got v=%b n=%0d want v=1 n=3", i, bus.incr_valid, bus.incr); end
        checks++; if (bus.decr_valid !== 1'b1 || bus.decr !== 2'd2) begin errors++; $display("FAIL burst_decr[%0d]: got v=%b n=%0d want v=1 n=2", i, bus.decr_valid, bus.decr); end
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0); settle();
      checks++; if (bus.pend_inc !== e_pinc || bus.incr_valid !== e_iv) begin errors++; $display("FAIL burst_drain[%0d]: got pend=%0d v=%b want %0d %b", i, bus.pend_inc, bus.incr_valid, e_pinc, e_iv); end
      tick();
    end
    settle();
    checks++; if (bus.pend_inc !== 4'd0 || bus.pend_dec !== 4'd0) begin errors++; $display("FAIL burst_empty: got %0d/%0d want 0/0", bus.pend_inc, bus.pend_dec); end
    tick();
  endtask

  task automatic test_simul();
    drive(1, 2, 1, 1, 0, 0); settle(); tick();
    drive(0, 0, 0, 0, 0, 0); settle();
    checks++; if (bus.incr_valid !== 1'b1 || bus.incr !== 2'd2) begin errors++; $display("FAIL simul_incr: got v=%b n=%0d want v=1 n=2", bus.incr_valid, bus.incr); end
    checks++; if (bus.decr_valid !== 1'b1 || bus.decr !== 2'd1) begin errors++; $display("FAIL simul_decr: got v=%b n=%0d want v=1 n=1", bus.decr_valid, bus.decr); end
    tick();
    settle();
    checks++; if (bus.incr_valid !== 1'b0 || bus.decr_valid !== 1'b0) begin errors++; $display("FAIL simul_after: got %b%b want 00", bus.incr_valid, bus.decr_valid); end
    tick();
  endtask

  task automatic test_reinit_backlog();
    drive(1, 3, 1, 1, 0, 0); settle(); tick();
    // cycle k: request raised with a backlog still draining; new offers must be refused
    drive(1, 2, 1, 2, 1, 'hA); settle();
    checks++; if (bus.inc_evt_ready !== 1'b0 || bus.dec_evt_ready !== 1'b0) begin errors++; $display("FAIL reinit_k_rdy: got %b%b want 00", bus.inc_evt_ready, bus.dec_evt_ready); end
    checks++; if (bus.incr_valid !== 1'b1 || bus.incr !== 2'd3) begin errors++; $display("FAIL reinit_k_drain: got v=%b n=%0d want v=1 n=3", bus.incr_valid, bus.incr); end
    tick();
    settle();
    checks++; if (bus.incr_valid !== 1'b0 || bus.decr_valid !== 1'b0) begin errors++; $display("FAIL reinit_k1_valids: got %b%b want 00", bus.incr_valid, bus.decr_valid); end
    checks++; if (bus.reinit !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL reinit_k1_state: got reinit=%b busy=%b want 0 1", bus.reinit, bus.busy); end
    tick();
    settle();
    checks++; if (bus.reinit !== 1'b1 || bus.initial_value !== 4'hA) begin errors++; $display("FAIL reinit_k2_load: got %b %h want 1 a", bus.reinit, bus.initial_value); end
    checks++; if (bus.reinit_ack !== 1'b0 || bus.incr_valid !== 1'b0) begin errors++; $display("FAIL reinit_k2_quiet: got ack=%b v=%b want 0 0", bus.reinit_ack, bus.incr_valid); end
    tick();
    settle();
    checks++; if (bus.reinit_ack !== 1'b1 || bus.reinit !== 1'b0 || bus.initial_value !== 4'h0) begin errors++; $display("FAIL reinit_k3_ack: got ack=%b reinit=%b iv=%h want 1 0 0", bus.reinit_ack, bus.reinit, bus.initial_value); end
    checks++; if (bus.pend_inc !== 4'd0 || bus.pend_dec !== 4'd0) begin errors++; $display("FAIL reinit_k3_pend: got %0d/%0d want 0/0", bus.pend_inc, bus.pend_dec); end
    tick();
    drive(0, 0, 0, 0, 0, 0); settle();
    checks++; if (bus.inc_evt_ready !== 1'b1 || bus.reinit_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reinit_k4_idle: got rdy=%b ack=%b busy=%b want 1 0 0", bus.inc_evt_ready, bus.reinit_ack, bus.busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    // Request held past the ack, so a second re-init follows immediately.
    drive(0, 0, 0, 0, 1, 5); settle(); tick();
    settle(); tick();
    settle();
    checks++; if (bus.reinit !== 1'b1 || bus.initial_value !== 4'h5) begin errors++; $display("FAIL b2b_load1: got %b %h want 1 5", bus.reinit, bus.initial_value); end
    tick();
    settle(); tick();
    settle();
    checks++; if (bus.inc_evt_ready !== 1'b0 || bus.reinit_ack !== 1'b0) begin errors++; $display("FAIL b2b_retake: got rdy=%b ack=%b want 0 0", bus.inc_evt_ready, bus.reinit_ack); end
    tick();
    settle();
    checks++; if (bus.busy !== 1'b1 || bus.reinit !== 1'b0) begin errors++; $display("FAIL b2b_flush2: got busy=%b reinit=%b want 1 0", bus.busy, bus.reinit); end
    tick();
    settle();
    checks++; if (bus.reinit !== 1'b1) begin errors++; $display("FAIL b2b_load2: got %b want 1", bus.reinit); end
    tick();
    settle();
    checks++; if (bus.reinit_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b want 1", bus.reinit_ack); end
    tick();
    drive(0, 0, 0, 0, 0, 0); settle();
    checks++; if (bus.inc_evt_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got rdy=%b busy=%b want 1 0", bus.inc_evt_ready, bus.busy); end
    tick();
  endtask

  task automatic test_reset_mid_reinit();
    drive(0, 0, 0, 0, 1, 9); settle(); tick();
    settle(); tick();
    settle();
    checks++; if (bus.reinit !== 1'b1 || bus.initial_value !== 4'h9) begin errors++; $display("FAIL midrst_load: got %b %h want 1 9", bus.reinit, bus.initial_value); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.reinit !== 1'b0 || bus.initial_value !== 4'h0) begin errors++; $display("FAIL midrst_drop: got %b %h want 0 0", bus.reinit, bus.initial_value); end
    checks++; if (bus.busy !== 1'b0 || bus.inc_evt_ready !== 1'b0) begin errors++; $display("FAIL midrst_quiet: got busy=%b rdy=%b want 0 0", bus.busy, bus.inc_evt_ready); end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (bus.reinit_ack !== 1'b0) begin errors++; $display("FAIL midrst_noack_in_rst: got %b want 0", bus.reinit_ack); end
    rst_n = 1'b1;
    model_reset();
    settle();
    checks++; if (bus.inc_evt_ready !== 1'b1 || bus.busy !== 1'b0 || bus.reinit !== 1'b0) begin errors++; $display("FAIL midrst_release: got rdy=%b busy=%b reinit=%b want 1 0 0", bus.inc_evt_ready, bus.busy, bus.reinit); end
    tick();
    settle();
    checks++; if (bus.reinit_ack !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_noack: got ack=%b busy=%b want 0 0", bus.reinit_ack, bus.busy); end
    tick();
  endtask

  task automatic test_random();
    bit req_on   = 1'b0;
    bit prev_ack = 1'b0;
    int rv       = 0;
    for (int n = 0; n < 600; n++) begin
      if (prev_ack) begin
        req_on = 1'b0;
      end else if (!req_on && ($urandom_range(0, 19) == 0)) begin
        req_on = 1'b1;
        rv     = int'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), req_on, rv);
      settle();
      checks++; if (bus.incr_valid !== e_iv) begin errors++; $display("FAIL rnd_incr_valid[%0d]: got %b want %b", n, bus.incr_valid, e_iv); end
      if (e_iv) begin
        checks++; if (bus.incr !== e_inc) begin errors++; $display("FAIL rnd_incr[%0d]: got %0d want %0d", n, bus.incr, e_inc); end
      end
      checks++; if (bus.decr_valid !== e_dv) begin errors++; $display("FAIL rnd_decr_valid[%0d]: got %b want %b", n, bus.decr_valid, e_dv); end
      if (e_dv) begin
        checks++; if (bus.decr !== e_dec) begin errors++; $display("FAIL rnd_decr[%0d]: got %0d want %0d", n, bus.decr, e_dec); end
      end
      checks++; if (bus.inc_evt_ready !== e_irdy) begin errors++; $display("FAIL rnd_inc_rdy[%0d]: got %b want %b", n, bus.inc_evt_ready, e_irdy); end
      checks++; if (bus.dec_evt_ready !== e_drdy) begin errors++; $display("FAIL rnd_dec_rdy[%0d]: got %b want %b", n, bus.dec_evt_ready, e_drdy); end
      checks++; if (bus.pend_inc !== e_pinc) begin errors++; $display("FAIL rnd_pend_inc[%0d]: got %0d want %0d", n, bus.pend_inc, e_pinc); end
      checks++; if (bus.pend_dec !== e_pdec) begin errors++; $display("FAIL rnd_pend_dec[%0d]: got %0d want %0d", n, bus.pend_dec, e_pdec); end
      checks++; if (bus.reinit !== e_reinit) begin errors++; $display("FAIL rnd_reinit[%0d]: got %b want %b", n, bus.reinit, e_reinit); end
      checks++; if (bus.initial_value !== e_init) begin errors++; $display("FAIL rnd_init_val[%0d]: got %h want %h", n, bus.initial_value, e_init); end
      checks++; if (bus.reinit_ack !== e_ack) begin errors++; $display("FAIL rnd_ack[%0d]: got %b want %b", n, bus.reinit_ack, e_ack); end
      checks++; if (bus.busy !== e_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, bus.busy, e_busy); end
      prev_ack = e_ack;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_reinit_backlog();
    test_back_to_back();
    test_reset_mid_reinit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_req_gen.md
# counter_req_gen

Upstream request generator for the 4-bit up/down `counter`. It absorbs bursty increment and decrement events from two producers into pending backlogs and drains them at up to 3 units per direction per cycle onto the counter's `incr`/`decr` ports. It also sequences counter re-initialisation through a request/acknowledge handshake on the counter's `reinit`/`initial_value` ports.

## Interface
- `PEND_W`, default 4: width of each pending backlog register; must be ≥ 3.
- `VALUE_W`, default 4: counter value width; matches `counter`.

Ports:
- `clk` in 1: clock; all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inc_evt_valid` in 1: increment event offered.
- `inc_evt_cnt` in 2: increment units, 0..3; 0 is accepted as a no-op.
- `inc_evt_ready` out 1: increment event accepted when valid && ready.
- `dec_evt_valid`, `dec_evt_cnt`, `dec_evt_ready`: same rules for decrements.
- `reinit_req` in 1: level request to reload the counter; held until ack.
- `reinit_value` in VALUE_W: load value; must be stable while `reinit_req` is high.
- `reinit_ack` out 1: one-cycle pulse; re-init issued.
- `incr_valid`, `incr[1:0]`, `decr_valid`, `decr[1:0]` out: drive `counter`.
- `reinit` out 1, `initial_value` out VALUE_W: drive `counter`.
- `pend_inc`, `pend_dec` out PEND_W: backlog status.
- `busy` out 1: backlog nonzero or FSM not IDLE.

## Operation
- **Backlog.** Each direction has a pending register `pend`.
  - `drain = min(pend, 3)`.
  - `incr = drain[1:0]`; `incr_valid = (drain != 0)`.
  - `pend_next = pend - drain + accepted_cnt`.
  - The counter consumes every cycle; there is no backpressure from it.
- **Ready.** `inc_evt_ready = rst_n && state==IDLE && !reinit_req && pend_inc <= 2^PEND_W - 4`. With `PEND_W`=4 this means `pend_inc` ≤ 12. Overflow is therefore impossible; there is no saturation logic. `dec_evt_ready` follows the same rule.
- **Independence.** The two directions are independent. No netting is done: with both backlogs nonzero, both valids assert in the same cycle.
- **FSM states:** IDLE, FLUSH, LOAD, ACK.
  - **IDLE → FLUSH** when `reinit_req`=1. Readies drop in that same cycle. Draining continues that cycle.
  - **FLUSH:** both backlogs clear to 0 at the end of the cycle, and the pending events are discarded. `incr_valid`/`decr_valid` are forced 0. → LOAD.
  - **LOAD:** `reinit`=1 and `initial_value`=`reinit_value` for exactly this cycle; all valids are 0. → ACK.
  - **ACK:** `reinit_ack`=1; `reinit_req` is ignored. → IDLE. The requester must present `reinit_req`=0 in the cycle after the ack, otherwise a new re-init starts.
- **Gating.** `reinit`=0 and `initial_value`=0 outside LOAD. Valids are 0 in FLUSH, LOAD and ACK. Readies are 0 outside IDLE.
- **Reset.** Asynchronous and active-low. A reset mid-operation, including mid-reinit, returns immediately to IDLE with backlogs 0. In-flight events are lost and no ack is produced.
- **Reset values:** all outputs 0, `pend_*`=0, state IDLE. Readies are 0 while `rst_n`=0 and 1 from the first cycle after release.

## Timing
- `incr`, `decr`, their valids, `reinit`, `initial_value`, `reinit_ack` and `busy` are decoded only from registers (Moore); they have no combinational path from inputs.
- Readies are combinational from state, `pend` and `reinit_req`.
- Event accepted in cycle k → first units on `incr`/`decr` in cycle k+1.
- Backlog B drains in ceil(B/3) cycles when no further events arrive.
- Re-init latency: `reinit_req` first sampled high in cycle k, FLUSH in k+1, `reinit` in k+2, `reinit_ack` in k+3.
- Throughput: 3 units per direction per cycle, sustained.

## Structure
- **Shared package `counter_pkg`:**
  - `STEP_W`=2, `STEP_MAX`=3, `VALUE_W`=4.
  - enum `reinit_state_t` {IDLE, FLUSH, LOAD, ACK}.
  - `counter` integration uses the same package.
- **Sub-module `counter_req_lane`,** instantiated twice, once for increments and once for decrements. It holds the `pend` register, the min-3 drain, the accept/ready compare, and a synchronous `flush` input.
- The top level holds the FSM and output gating.

## Test plan
- **Single event:** reset, then `inc_evt_cnt`=3 accepted in cycle 1 → `incr_valid`=1, `incr`=3 in cycle 2; `pend_inc`=0 in cycle 3.
- **Burst to full:** `inc_evt_cnt`=3 offered every cycle → `pend_inc` rises by at most 3 per cycle net of drain, ready drops once `pend_inc` exceeds 12, and `incr`=3 is held every cycle. Check that the backlog drains to 0.
- **Simultaneous directions:** `inc` 2 and `dec` 1 in the same cycle → next cycle `incr`=2/valid, `decr`=1/valid, both in one cycle.
- **Re-init with backlog:** `pend_inc`=7, raise `reinit_req` with `reinit_value`=4'hA in cycle k → readies 0 in k; `incr_valid`=0 in k+1; `reinit`=1 with `initial_value`=A in k+2; `reinit_ack` in k+3; `pend_inc`=0; ready returns in k+4.
- **Reset mid-reinit:** assert `rst_n`=0 during LOAD → `reinit` drops immediately, no ack, and after release state is IDLE with all outputs 0.
